// File: rtl/cic_decim_ctrl.sv
// Sequencer for a 3rd-order CIC decimator: integrator clear, decimation strobe,
// settling-output discard and a small valid/ready output FIFO.
module cic_decim_ctrl #(
   parameter int DATA_W        = 25,
   parameter int RATIO_W       = 8,
   parameter int DEFAULT_RATIO = 64,
   parameter int SETTLE        = 3,
   parameter int DEPTH         = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               ratio_wr,
   input  logic [RATIO_W-1:0] ratio_val,
   input  logic [DATA_W-1:0]  cic_data,
   output logic               integ_clear,
   output logic               dec_strobe,
   output logic [DATA_W-1:0]  dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               overflow,
   input  logic               ovf_clr,
   output logic               running
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   state_t              state_r, next_state_s;
   logic [RATIO_W-1:0]  cnt_r, cnt_next_s;
   logic [RATIO_W-1:0]  ratio_r, ratio_next_s;
   logic [RATIO_W-1:0]  pend_val_r, pend_val_next_s;
   logic                pend_r, pend_next_s;
   logic [SW-1:0]       settle_r, settle_next_s;
   logic                cap_pend_r, cap_next_s;
   logic                flush_s;
   logic                strobe_s;
   logic [RATIO_W-1:0]  clamp_s;

   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
   logic [AW:0]         count_r;
   logic                overflow_r;
   logic                push_req_s, pop_s, full_s, push_s, drop_s;

   assign strobe_s   = ((state_r == ST_SETTLE) || (state_r == ST_RUN)) &&
                       (cnt_r == (ratio_r - RATIO_W'(1)));
   assign clamp_s    = (ratio_val < RATIO_W'(2)) ? RATIO_W'(2) : ratio_val;

   // A capture is cancelled outright when enable drops during its pending cycle.
   assign push_req_s = cap_pend_r && enable;
   assign pop_s      = (count_r != '0) && dout_ready;
   assign full_s     = (count_r == (AW+1)'(DEPTH));
   assign push_s     = push_req_s && (!full_s || pop_s);
   assign drop_s     = push_req_s && full_s && !pop_s;

   // Next-state, counter, settle count and ratio bookkeeping.
   always_comb begin
      next_state_s    = state_r;
      cnt_next_s      = cnt_r;
      settle_next_s   = settle_r;
      ratio_next_s    = ratio_r;
      pend_next_s     = pend_r;
      pend_val_next_s = pend_val_r;
      cap_next_s      = 1'b0;
      flush_s         = 1'b0;
      if (!enable) begin
         next_state_s = ST_IDLE;
         cnt_next_s   = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               next_state_s = ST_CLEAR;
               flush_s      = 1'b1;
            end
            ST_CLEAR: begin
               next_state_s  = ST_SETTLE;
               cnt_next_s    = '0;
               settle_next_s = '0;
            end
            ST_SETTLE, ST_RUN: begin
               if (strobe_s) begin
                  cnt_next_s = '0;
                  cap_next_s = (state_r == ST_RUN);
                  if (pend_r) begin
                     // New ratio restarts the discard window, even out of RUN.
                     ratio_next_s  = pend_val_r;
                     pend_next_s   = 1'b0;
                     next_state_s  = ST_SETTLE;
                     settle_next_s = '0;
                  end else if ((state_r == ST_SETTLE) && (settle_r == SW'(SETTLE - 1))) begin
                     next_state_s = ST_RUN;
                  end else if (state_r == ST_SETTLE) begin
                     settle_next_s = settle_r + SW'(1);
                  end else begin
                     next_state_s = ST_RUN;
                  end
               end else begin
                  cnt_next_s = cnt_r + RATIO_W'(1);
               end
            end
            default: begin
               next_state_s = ST_IDLE;
            end
         endcase
      end
      if (ratio_wr && (state_r == ST_IDLE)) begin
         ratio_next_s = clamp_s;
         pend_next_s  = 1'b0;
      end else if (ratio_wr) begin
         pend_next_s     = 1'b1;
         pend_val_next_s = clamp_s;
      end else if ((state_r == ST_IDLE) && pend_r) begin
         ratio_next_s = pend_val_r;
         pend_next_s  = 1'b0;
      end else begin
         pend_val_next_s = pend_val_r;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         settle_r   <= '0;
         ratio_r    <= RATIO_W'(DEFAULT_RATIO);
         pend_r     <= 1'b0;
         pend_val_r <= '0;
         cap_pend_r <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         cnt_r      <= cnt_next_s;
         settle_r   <= settle_next_s;
         ratio_r    <= ratio_next_s;
         pend_r     <= pend_next_s;
         pend_val_r <= pend_val_next_s;
         cap_pend_r <= cap_next_s;
      end
   end

   // Output FIFO storage, pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_r[k] <= '0;
         end
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
         end else begin
            if (push_s) begin
               mem_r[wr_ptr_r] <= cic_data;
               wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (ovf_clr) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign integ_clear = (state_r == ST_CLEAR);
   assign running     = (state_r == ST_RUN);
   assign dec_strobe  = strobe_s;
   assign dout        = mem_r[rd_ptr_r];
   assign dout_valid  = (count_r != '0);
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl with DEFAULT_RATIO=4, SETTLE=3, DEPTH=4.
module tb_cic_decim_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        ratio_wr;
   logic [7:0]  ratio_val;
   logic [24:0] cic_data;
   logic        integ_clear;
   logic        dec_strobe;
   logic [24:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        overflow;
   logic        ovf_clr;
   logic        running;

   int n_cmp = 0;
   int n_mis = 0;
   int j;

   always #5 clk = ~clk;

   cic_decim_ctrl #(
      .DATA_W(25), .RATIO_W(8), .DEFAULT_RATIO(4), .SETTLE(3), .DEPTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .ratio_wr(ratio_wr),
      .ratio_val(ratio_val), .cic_data(cic_data), .integ_clear(integ_clear),
      .dec_strobe(dec_strobe), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .overflow(overflow), .ovf_clr(ovf_clr),
      .running(running)
   );

   function automatic logic [24:0] f(input int i);
      return 25'(32'h0012_3400 + i);
   endfunction

   task automatic chk(input string tag, input int step, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
      end
   endtask

   // Expected behaviour for the long run (j = cycles after the edge entering SETTLE).
   function automatic logic ea_strobe(input int jj);
      if (jj < 0) return 1'b0;
      else if (jj <= 83) return (jj % 4 == 3);
      else if (jj <= 124) return ((jj - 84) % 8 == 7);
      else return 1'b0;
   endfunction

   function automatic logic ea_run(input int jj);
      return ((jj >= 12) && (jj <= 83)) || ((jj >= 108) && (jj <= 124));
   endfunction

   function automatic logic ea_valid(input int jj);
      if (jj < 17) return 1'b0;
      else if (jj <= 40) return (jj % 4 == 1);
      else if (jj <= 77) return 1'b1;
      else if (jj <= 84) return (jj % 4 == 1);
      else if (jj <= 116) return 1'b0;
      else if (jj <= 127) return 1'b1;
      else return 1'b0;
   endfunction

   function automatic int ea_head(input int jj);
      if (jj <= 40) return jj;
      else if (jj <= 68) return 41;
      else if (jj <= 72) return 45;
      else if (jj == 73) return 49;
      else if (jj == 74) return 53;
      else if (jj == 75) return 69;
      else if (jj == 76) return 73;
      else if (jj <= 116) return jj;
      else return 117;
   endfunction

   function automatic logic ea_ovf(input int jj);
      return ((jj >= 57) && (jj <= 62)) || (jj == 65);
   endfunction

   function automatic logic ea_ready(input int i);
      if (i < 39) return 1'b1;
      else if (i <= 68) return 1'b0;
      else if (i == 69) return 1'b1;
      else if (i <= 72) return 1'b0;
      else if (i <= 117) return 1'b1;
      else if (i <= 127) return 1'b0;
      else return 1'b1;
   endfunction

   task automatic chk_reset_outs(input int step);
      chk("rst_integ_clear", step, 32'(integ_clear), 32'd0);
      chk("rst_dec_strobe",  step, 32'(dec_strobe),  32'd0);
      chk("rst_dout_valid",  step, 32'(dout_valid),  32'd0);
      chk("rst_dout",        step, 32'(dout),        32'd0);
      chk("rst_overflow",    step, 32'(overflow),    32'd0);
      chk("rst_running",     step, 32'(running),     32'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      enable     = 1'b0;
      ratio_wr   = 1'b0;
      ratio_val  = 8'd0;
      cic_data   = 25'd0;
      dout_ready = 1'b1;
      ovf_clr    = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outs(-1);

      // Long run at R=4: settle, capture, overflow, full+pop, ratio change, enable drop.
      reset_n = 1'b1;
      enable  = 1'b1;
      for (int i = 0; i <= 132; i++) begin
         @(negedge clk);
         j = i - 1;
         chk("a_integ_clear", i, 32'(integ_clear), 32'(i == 0));
         chk("a_dec_strobe",  i, 32'(dec_strobe),  32'(ea_strobe(j)));
         chk("a_running",     i, 32'(running),     32'(ea_run(j)));
         chk("a_overflow",    i, 32'(overflow),    32'(ea_ovf(j)));
         if (j != 85) begin
            chk("a_dout_valid", i, 32'(dout_valid), 32'(ea_valid(j)));
            if (ea_valid(j)) begin
               chk("a_dout", i, 32'(dout), 32'(f(ea_head(j))));
            end
         end
         cic_data   = f(i);
         dout_ready = ea_ready(i);
         ovf_clr    = (i == 61) || (i == 63) || (i == 66);
         ratio_wr   = (i == 82);
         ratio_val  = 8'd8;
         enable     = (i < 125);
      end

      // Ratio 0 written in IDLE clamps to 2; R=2 must sustain with ready held.
      @(negedge clk);
      ratio_wr  = 1'b1;
      ratio_val = 8'd0;
      @(negedge clk);
      ratio_wr   = 1'b0;
      enable     = 1'b1;
      dout_ready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         j = i - 1;
         chk("b_integ_clear", i, 32'(integ_clear), 32'(i == 0));
         chk("b_dec_strobe",  i, 32'(dec_strobe),  32'((j >= 0) && (j % 2 == 1)));
         chk("b_running",     i, 32'(running),     32'(j >= 6));
         chk("b_dout_valid",  i, 32'(dout_valid),  32'((j >= 9) && (j % 2 == 1)));
         if ((j >= 9) && (j % 2 == 1)) begin
            chk("b_dout", i, 32'(dout), 32'(f(j)));
         end
         cic_data = f(i);
      end

      // Asynchronous reset in the middle of RUN, enable kept high throughout.
      reset_n = 1'b0;
      #1;
      chk_reset_outs(100);
      @(negedge clk);
      chk_reset_outs(101);
      reset_n = 1'b1;
      for (int i = 0; i <= 24; i++) begin
         @(negedge clk);
         j = i - 1;
         chk("c_integ_clear", i, 32'(integ_clear), 32'(i == 0));
         chk("c_dec_strobe",  i, 32'(dec_strobe),  32'((j >= 0) && (j % 4 == 3)));
         chk("c_running",     i, 32'(running),     32'(j >= 12));
         chk("c_dout_valid",  i, 32'(dout_valid),  32'((j >= 17) && (j % 4 == 1)));
         if ((j >= 17) && (j % 4 == 1)) begin
            chk("c_dout", i, 32'(dout), 32'(f(j)));
         end
         cic_data = f(i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencer for the 3rd-order CIC decimator behind the sigma-delta modulator. It generates the decimation strobe for the comb section, clears the integrators on start, and discards the filter's settling outputs after start or a ratio change. It captures valid decimated words into a small FIFO with a valid/ready output. It sits between `cic3` and the downstream consumer, on the modulator clock.

## Interface
- `DATA_W`, 25, width of CIC output word
- `RATIO_W`, 8, width of decimation ratio
- `DEFAULT_RATIO`, 64, ratio loaded at reset (must be >= 2)
- `SETTLE`, 3, decimated outputs discarded after start or ratio change (CIC order)
- `DEPTH`, 4, output FIFO entries (power of 2)

Ports:
- `clk`  in  1  modulator clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request; level-sensitive
- `ratio_wr`  in  1  one-cycle write of `ratio_val`
- `ratio_val`  in  RATIO_W  requested decimation ratio R
- `cic_data`  in  DATA_W  CIC filter output
- `integ_clear`  out  1  one-cycle clear pulse to the CIC integrators
- `dec_strobe`  out  1  one-cycle decimation pulse to the CIC comb section
- `dout`  out  DATA_W  FIFO head word
- `dout_valid`  out  1  FIFO non-empty
- `dout_ready`  in  1  consumer accepts `dout` when `dout_valid` is also high
- `overflow`  out  1  sticky flag: a sample was dropped
- `ovf_clr`  in  1  clears `overflow`
- `running`  out  1  high only in RUN

## Operation
- States: IDLE, CLEAR, SETTLE, RUN. All outputs are registered or decoded from registered state (Moore).
- IDLE: counter held at 0. With `enable`=1, go to CLEAR.
- CLEAR: lasts one cycle. `integ_clear`=1, counter=0, FIFO flushed, settle count=0. Then go to SETTLE.
- SETTLE and RUN: counter increments 0..R-1 and wraps. `dec_strobe`=1 when count==R-1.
- SETTLE: count strobes. The edge ending the SETTLE-th strobe cycle moves to RUN. No captures happen in SETTLE.
- RUN: each strobe sets `cap_pend`. On the next edge, `cic_data` is written to the FIFO and `cap_pend` clears.
- `enable`=0 in any state: go to IDLE at the next edge. `cap_pend` clears and no capture occurs. FIFO contents stay readable.
- Ratio handling:
  - `ratio_wr` with `ratio_val`<2 stores 2 (clamp).
  - In IDLE, the write takes effect at the next edge.
  - In CLEAR, SETTLE or RUN, the value is held as pending. It is applied at the edge ending the next strobe cycle, where the counter restarts at 0.
  - Applying a pending ratio forces SETTLE with settle count=0, even from RUN.
  - A later `ratio_wr` before application overwrites the pending value.
- FIFO write when full:
  - With a pop in the same cycle, the write succeeds and occupancy is unchanged.
  - Without a pop, the word is dropped and `overflow` is set.
- Pop occurs when `dout_valid` and `dout_ready` are both high. `dout` is the head word and is stable while `dout_valid`=1 and `dout_ready`=0.
- `ovf_clr` clears `overflow`. If `ovf_clr` and a new drop occur in the same cycle, set wins.

## Timing
- Reset values: state=IDLE, counter=0, R=`DEFAULT_RATIO`, no pending ratio, FIFO empty. Outputs: `integ_clear`=0, `dec_strobe`=0, `dout_valid`=0, `dout`=0, `overflow`=0, `running`=0.
- Let edge E0 be the edge that enters CLEAR.
  - SETTLE is entered at E1.
  - Strobes are high in cycles E1+R-1+kR, k=0,1,…
  - RUN is entered after SETTLE strobes.
  - The first capture strobe is at cycle E1+(SETTLE+1)R-1.
  - The FIFO write happens at the following edge +1; `dout_valid` is high in the cycle after that write.
- A pop deasserts `dout_valid` (when the FIFO becomes empty) at the next edge. There is no combinational path from `dout_ready` to `dout_valid`.
- Throughput: one word per R cycles. R=2 must sustain with `dout_ready` held at 1.

## Test plan
- Reset mid-run → all outputs return to reset values asynchronously. After release with `enable` held, exactly one `integ_clear` pulse occurs before any strobe.
- `DEFAULT_RATIO`=4, `SETTLE`=3, `enable` raised, `dout_ready`=1:
  - strobes every 4 cycles;
  - the first 3 strobes produce no FIFO write;
  - the 4th strobe's `cic_data`+1-cycle value appears on `dout` 2 edges after that strobe.
- R=4, `dout_ready`=0 for 30 words: exactly 4 words are held in order, `overflow`=1 from the 5th capture, and `ovf_clr` clears it. A simultaneous `ovf_clr` and drop leaves it set.
- In RUN with R=4, write `ratio_val`=8 mid-interval:
  - the old period completes;
  - the counter restarts and the state goes to SETTLE;
  - 3 strobes at period 8 are discarded, then captures resume every 8 cycles.
- `ratio_val`=0 written in IDLE → strobe period 2. `enable` dropped one cycle after a RUN strobe → no FIFO write, state IDLE, FIFO still drains.
- FIFO full, capture and pop in the same cycle → occupancy stays 4, `overflow` stays 0, and order is preserved.
